dvi_tx_tmds_encoder: RTL and testbench



---
 rtl/dvi_tx_tmds_encoder_pkg.sv | 25 ++
 rtl/dvi_tx_tmds_encoder_if.sv | 25 ++
 rtl/dvi_tx_tmds_encoder.sv | 110 +++++++++++
 tb/tb_dvi_tx_tmds_encoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_tx_tmds_encoder_pkg.sv
// Shared TMDS definitions for the three DVI lanes: control tokens, disparity width, popcount.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package dvi_tmds_pkg;

    // Signed running-disparity width; cnt stays within [-10,+10]
    localparam int CNT_W = 5;

    // Control tokens emitted during blanking, indexed by {c1,c0}
    localparam logic [9:0] CTRL_TOK_00 = 10'h354;
    localparam logic [9:0] CTRL_TOK_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOK_10 = 10'h154;
    localparam logic [9:0] CTRL_TOK_11 = 10'h2AB;

    // Number of set bits in a byte (0..8)
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/dvi_tx_tmds_encoder_if.sv
// Per-lane pixel/control input and 10-bit TMDS character output bundle.
// Latency: n/a (wiring only).
// Backpressure: none; one character is accepted and produced every pixel clock.
interface dvi_tx_tmds_encoder_if;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [9:0] tmds_data;

    // Video source side: drives pixel/control, observes the encoded character
    modport master (
        output de,
        output data,
        output ctrl,
        input  tmds_data
    );

    // Encoder side
    modport slave (
        input  de,
        input  data,
        input  ctrl,
        output tmds_data
    );
endinterface

// File: rtl/dvi_tx_tmds_encoder.sv
// DVI 1.0 TMDS lane encoder: 8b pixel / 2b control -> DC-balanced 10b character.
// Latency: 2 pixel clocks (transition-minimise stage, then DC-balance stage).
// Backpressure: none; one character in and one out on every clock.
module dvi_tx_tmds_encoder
    import dvi_tmds_pkg::*;
(
    input  logic                   pixel_clock,
    input  logic                   reset,
    dvi_tx_tmds_encoder_if.slave   tmds_if
);

    // Stage-1 combinational signals
    logic [3:0] w_n1d;
    logic       w_use_xnor;
    logic [8:0] w_qm;

    // Stage-1 registers: q_m with de/ctrl delayed alongside
    logic [8:0] r_qm1;
    logic       r_de1;
    logic [1:0] r_ctrl1;

    // Stage-2 combinational signals
    logic [3:0]              w_n1q;
    logic [3:0]              w_n0q;
    logic signed [CNT_W-1:0] w_diff;
    logic signed [CNT_W-1:0] w_two_qm8;
    logic signed [CNT_W-1:0] w_two_nqm8;
    logic [9:0]              w_out;
    logic signed [CNT_W-1:0] w_cnt_nxt;

    // Stage-2 registers: output character and running disparity
    logic [9:0]              r_tmds;
    logic signed [CNT_W-1:0] r_cnt;

    // Choose XOR/XNOR chaining to minimise transitions in the 8 data bits
    always_comb begin
        w_n1d      = popcount8(tmds_if.data);
        w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !tmds_if.data[0]);
        w_qm       = 9'd0;
        w_qm[0]    = tmds_if.data[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ tmds_if.data[i])
                                 :  (w_qm[i-1] ^ tmds_if.data[i]);
        end
        w_qm[8]    = ~w_use_xnor;
    end

    // Stage 1: register q_m; de and ctrl ride along so a de edge never splits stages
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_qm1   <= 9'd0;
            r_de1   <= 1'b0;
            r_ctrl1 <= 2'b00;
        end else begin
            r_qm1   <= w_qm;
            r_de1   <= tmds_if.de;
            r_ctrl1 <= tmds_if.ctrl;
        end
    end

    // Disparity of q_m[7:0] and the 2*q_m[8] correction terms, all signed
    always_comb begin
        w_n1q      = popcount8(r_qm1[7:0]);
        w_n0q      = 4'd8 - w_n1q;
        w_diff     = $signed({1'b0, w_n1q}) - $signed({1'b0, w_n0q});
        w_two_qm8  = $signed({3'b000,  r_qm1[8], 1'b0});
        w_two_nqm8 = $signed({3'b000, ~r_qm1[8], 1'b0});
    end

    // Select token or DC-balanced character and the next running disparity
    always_comb begin
        w_out     = CTRL_TOK_00;
        w_cnt_nxt = r_cnt;
        if (!r_de1) begin
            // Blanking clears disparity so the next active run starts balanced
            w_cnt_nxt = '0;
            case (r_ctrl1)
                2'b00:   w_out = CTRL_TOK_00;
                2'b01:   w_out = CTRL_TOK_01;
                2'b10:   w_out = CTRL_TOK_10;
                default: w_out = CTRL_TOK_11;
            endcase
        end else if ((r_cnt == '0) || (w_n1q == w_n0q)) begin
            w_out     = {~r_qm1[8], r_qm1[8], r_qm1[8] ? r_qm1[7:0] : ~r_qm1[7:0]};
            w_cnt_nxt = r_qm1[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if (((r_cnt > 0) && (w_n1q > w_n0q)) ||
                     ((r_cnt < 0) && (w_n0q > w_n1q))) begin
            // Invert to pull disparity back toward zero
            w_out     = {1'b1, r_qm1[8], ~r_qm1[7:0]};
            w_cnt_nxt = r_cnt + w_two_qm8 - w_diff;
        end else begin
            w_out     = {1'b0, r_qm1[8], r_qm1[7:0]};
            w_cnt_nxt = r_cnt + w_diff - w_two_nqm8;
        end
    end

    // Stage 2: register the character and running disparity
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_tmds <= CTRL_TOK_00;
            r_cnt  <= '0;
        end else begin
            r_tmds <= w_out;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign tmds_if.tmds_data = r_tmds;

endmodule

// File: tb/tb_dvi_tx_tmds_encoder.sv
// Bench for the TMDS lane encoder: directed literal vectors plus a randomised run
// against an integer-level character model, with output disparity bound checking.
module tb_dvi_tx_tmds_encoder;

    logic pixel_clock;
    logic reset;

    dvi_tx_tmds_encoder_if tmds_if();

    dvi_tx_tmds_encoder dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .tmds_if     (tmds_if)
    );

    initial begin
        pixel_clock = 1'b0;
        forever #5 pixel_clock = ~pixel_clock;
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge pixel_clock) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [9:0] exp;
        bit         de;
    } exp_t;

    exp_t exp_q[$];

    // Model running disparity (ones minus zeros of emitted data characters)
    int m_cnt = 0;

    function automatic int ones(input logic [9:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) n += int'(v[i]);
        return n;
    endfunction

    // Character-level encoder model working in plain integers
    function automatic logic [9:0] model_enc(input bit d, input logic [7:0] dat,
                                             input logic [1:0] c);
        logic [7:0] qm;
        bit         xn;
        bit         qm8;
        int         n1d, n1q, n0q;
        logic [9:0] o;
        if (!d) begin
            m_cnt = 0;
            case (c)
                2'b00:   o = 10'h354;
                2'b01:   o = 10'h0AB;
                2'b10:   o = 10'h154;
                default: o = 10'h2AB;
            endcase
            return o;
        end
        n1d = ones({2'b00, dat});
        xn  = (n1d > 4) || (n1d == 4 && dat[0] == 1'b0);
        qm[0] = dat[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ dat[i]) : (qm[i-1] ^ dat[i]);
        qm8 = !xn;
        n1q = ones({2'b00, qm});
        n0q = 8 - n1q;
        if (m_cnt == 0 || n1q == n0q) begin
            o = {~qm8, qm8, (qm8 ? qm : ~qm)};
            m_cnt += qm8 ? (n1q - n0q) : (n0q - n1q);
        end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
            o = {1'b1, qm8, ~qm};
            m_cnt += 2 * int'(qm8) + (n0q - n1q);
        end else begin
            o = {1'b0, qm8, qm};
            m_cnt += (n1q - n0q) - 2 * int'(!qm8);
        end
        return o;
    endfunction

    // Drive one character, queue its model expectation two clocks ahead
    task automatic drive(input bit d, input logic [7:0] dat, input logic [1:0] c);
        exp_t e;
        @(posedge pixel_clock);
        #1;
        tmds_if.de   = d;
        tmds_if.data = dat;
        tmds_if.ctrl = c;
        e.due = cyc + 2;
        e.exp = model_enc(d, dat, c);
        e.de  = d;
        exp_q.push_back(e);
        vectors++;
        if (m_cnt > 10 || m_cnt < -10) begin
            miscompares++;
            $display("FAIL model_cnt_bound got %0d required |cnt|<=10", m_cnt);
        end
    endtask

    // Drive one character and pin the model against a hand-computed literal
    task automatic drive_lit(input bit d, input logic [7:0] dat, input logic [1:0] c,
                             input logic [9:0] lit, input int lit_cnt);
        drive(d, dat, c);
        vectors++;
        if (exp_q[exp_q.size()-1].exp !== lit) begin
            miscompares++;
            $display("FAIL model_char got %h required %h", exp_q[exp_q.size()-1].exp, lit);
        end
        vectors++;
        if (m_cnt != lit_cnt) begin
            miscompares++;
            $display("FAIL model_cnt got %0d required %0d", m_cnt, lit_cnt);
        end
    endtask

    // Compare process: DUT output vs model, plus output-disparity bound
    int dc = 0;
    always @(negedge pixel_clock) begin
        if (reset) begin
            dc = 0;
            vectors++;
            if (tmds_if.tmds_data !== 10'h354) begin
                miscompares++;
                $display("FAIL reset_out got %h required 354", tmds_if.tmds_data);
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (tmds_if.tmds_data !== e.exp) begin
                miscompares++;
                $display("FAIL char@%0d got %h required %h", cyc, tmds_if.tmds_data, e.exp);
            end
            if (e.de) begin
                dc += 2 * ones(tmds_if.tmds_data) - 10;
                vectors++;
                if (dc > 10 || dc < -10) begin
                    miscompares++;
                    $display("FAIL disparity@%0d got %0d required |d|<=10", cyc, dc);
                end
            end else begin
                dc = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Expected characters/cnt for nine 8'h00 characters from cnt=0
    logic [9:0] zero_chr [9] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100,
                                 10'h3FF, 10'h100, 10'h3FF, 10'h100};
    int         zero_cnt [9] = '{-8, 2, -6, 4, -4, 6, -2, 8, 0};
    logic [9:0] tok      [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    initial begin
        tmds_if.de   = 1'b0;
        tmds_if.data = 8'h00;
        tmds_if.ctrl = 2'b00;
        reset        = 1'b0;
        #2 reset     = 1'b1;
        repeat (3) @(posedge pixel_clock);
        #1 reset = 1'b0;

        // Output holds 354 across reset release while ctrl stays 00
        for (int i = 0; i < 3; i++) drive_lit(1'b0, 8'h00, 2'b00, 10'h354, 0);

        // Control token sweep
        for (int i = 0; i < 4; i++) drive_lit(1'b0, 8'h00, 2'(i), tok[i], 0);

        // Nine 8'h00 characters from cnt=0
        for (int i = 0; i < 9; i++) drive_lit(1'b1, 8'h00, 2'b00, zero_chr[i], zero_cnt[i]);

        // 8'hFF from cnt=0
        drive_lit(1'b0, 8'h00, 2'b00, 10'h354, 0);
        drive_lit(1'b1, 8'hFF, 2'b00, 10'h200, -8);

        // De-drop: blanking clears cnt
        drive_lit(1'b0, 8'h00, 2'b00, 10'h354, 0);
        for (int i = 0; i < 3; i++) drive_lit(1'b1, 8'h00, 2'b00, zero_chr[i], zero_cnt[i]);
        drive_lit(1'b0, 8'h00, 2'b00, 10'h354, 0);
        drive_lit(1'b1, 8'h00, 2'b00, 10'h100, -8);

        // Random run biased toward 00/FF runs, with one mid-stream reset
        for (int i = 0; i < 10000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (i == 5000) begin
                @(posedge pixel_clock);
                #1 reset = 1'b1;
                #1;
                vectors++;
                if (tmds_if.tmds_data !== 10'h354) begin
                    miscompares++;
                    $display("FAIL async_reset got %h required 354", tmds_if.tmds_data);
                end
                exp_q.delete();
                m_cnt = 0;
                tmds_if.de = 1'b0;
                tmds_if.ctrl = 2'b00;
                repeat (3) @(posedge pixel_clock);
                #1 reset = 1'b0;
                // First post-reset data character must encode from cnt=0
                drive_lit(1'b1, 8'h00, 2'b00, 10'h100, -8);
            end else if (r < 6) begin
                drive(1'b0, 8'($urandom), 2'($urandom_range(0, 3)));
            end else if (r < 30) begin
                drive(1'b1, 8'h00, 2'b00);
            end else if (r < 50) begin
                drive(1'b1, 8'hFF, 2'b00);
            end else begin
                drive(1'b1, 8'($urandom), 2'($urandom_range(0, 3)));
            end
        end

        repeat (4) @(posedge pixel_clock);
        @(negedge pixel_clock);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
